alarm_annunciator: RTL
======================

// Module: alarm_annunciator
// PURPOSE
//  Output-side counterpart of the front-panel input conditioner: converts alarm events and
//  conditioned button/switch levels into board outputs (piezo buzzer tone, alarm LED).
//  Owns the ring/snooze/timeout state machine. Sits between the timekeeping/compare logic
//  and the board I/O pins.
// PARAMETERS
//  TONE_DIV      25000  clk cycles per buzzer half-period (1 kHz tone at 50 MHz)
//  BEAT_CYCLES   12500000  clk cycles per cadence half-period (beep on/off); used with the macro only
//  SNOOZE_SEC    300    sec_tick pulses spent in SNOOZED before re-ringing (>=1)
//  RING_SEC      60     sec_tick pulses spent in RINGING before auto-stop (>=1)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  sec_tick     in   1   one-cycle pulse, once per second
//  alarm_hit    in   1   one-cycle pulse: current time equals alarm time
//  alarm_en     in   1   level: alarm armed (conditioned switch)
//  snooze_btn   in   1   level, active-high (conditioned button)
//  stop_btn     in   1   level, active-high (conditioned button)
//  buzzer       out  1   square-wave drive to piezo
//  led_alarm    out  1   alarm indicator LED
//  ringing      out  1   state == RINGING
//  snoozed      out  1   state == SNOOZED
//  snooze_left  out  W   seconds remaining in snooze; W = $clog2(SNOOZE_SEC+1)
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; all counters 0; button history regs = 1.
//  - Buttons: internal rising-edge detect (prev register). Button held through reset release
//    produces no edge; it must be released and pressed again.
//  - States: IDLE, RINGING, SNOOZED. All outputs are registered; a transition is visible
//    on ringing/snoozed one cycle after the causing input.
//  - IDLE: alarm_hit && alarm_en -> RINGING, ring_cnt <= RING_SEC. Button edges ignored.
//  - RINGING, priority high->low in the same cycle:
//      !alarm_en -> IDLE; stop edge -> IDLE; snooze edge -> SNOOZED, snooze_left <= SNOOZE_SEC;
//      sec_tick -> ring_cnt-1; if ring_cnt==1 -> IDLE (timeout after exactly RING_SEC ticks).
//      alarm_hit while RINGING is ignored (no restart of ring_cnt).
//  - SNOOZED: !alarm_en -> IDLE; stop edge -> IDLE; snooze edge and alarm_hit ignored;
//      sec_tick -> snooze_left-1; if snooze_left==1 -> RINGING, ring_cnt <= RING_SEC,
//      snooze_left <= 0.
//  - snooze_left is 0 outside SNOOZED; counts SNOOZE_SEC..1 while SNOOZED; never wraps.
//  - Tone: counter runs only in RINGING; buzzer toggles when counter reaches TONE_DIV-1,
//    counter then restarts at 0. Entering RINGING starts with buzzer=0, counter=0.
//    Leaving RINGING forces buzzer=0 and clears counter the next cycle.
//  - led_alarm: RINGING -> 1; SNOOZED -> toggles on each sec_tick (starts 1 on entry);
//    IDLE -> 0.
//  - sec_tick coincident with a button edge: button action wins, tick is not applied.
//  - Reset mid-ring/mid-snooze: immediate return to IDLE, buzzer and LED 0 asynchronously.
// CONFIGURATION
//  ALARM_CADENCE_EN defined: beat counter (period 2*BEAT_CYCLES) runs in RINGING, starts
//    in "on" phase at entry; buzzer = tone AND beat_on, so tone sounds in bursts;
//    led_alarm in RINGING follows beat_on instead of constant 1.
//  Not defined: no beat counter, BEAT_CYCLES unused; continuous tone while RINGING.
// TESTING (TONE_DIV=4, BEAT_CYCLES=8, SNOOZE_SEC=3, RING_SEC=5, sec_tick every 20 clk)
//  1 alarm_en=1, alarm_hit pulse -> ringing=1 next cycle; buzzer period 8 clk starting 0;
//    5 sec_ticks later ringing=0, buzzer=0, led_alarm=0.
//  2 Ringing, snooze_btn 0->1 -> snoozed=1, snooze_left=3, buzzer=0; after ticks 2,1 then
//    third tick -> ringing=1, snooze_left=0; led_alarm toggles each tick while snoozed.
//  3 Ringing, stop_btn and snooze_btn rise same cycle -> IDLE (stop wins); held buttons
//    cause no further action.
//  4 Ringing, alarm_hit again mid-ring -> ring_cnt not reloaded, timeout at original time;
//    alarm_en=0 in SNOOZED -> IDLE next cycle.
//  5 stop_btn held high across reset release, alarm rings -> stays RINGING until release
//    and re-press; rst asserted mid-ring -> all outputs 0 without a clk edge.
//  6 With ALARM_CADENCE_EN: buzzer toggles only during 8-clk on windows, 0 during 8-clk off
//    windows; led_alarm matches beat_on. Without: tone continuous, led_alarm constant 1.

Source files
------------

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: ring/snooze/timeout state machine driving the piezo tone and alarm LED.
// Optional macro ALARM_CADENCE_EN gates the tone into on/off bursts of BEAT_CYCLES clocks.
module alarm_annunciator #(
  parameter int  TONE_DIV    = 25000,
  parameter int  BEAT_CYCLES = 12500000,
  parameter int  SNOOZE_SEC  = 300,
  parameter int  RING_SEC    = 60,
  localparam int W           = $clog2(SNOOZE_SEC + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sec_tick,
  input  logic         alarm_hit,
  input  logic         alarm_en,
  input  logic         snooze_btn,
  input  logic         stop_btn,
  output logic         buzzer,
  output logic         led_alarm,
  output logic         ringing,
  output logic         snoozed,
  output logic [W-1:0] snooze_left
);
  localparam int RW = $clog2(RING_SEC + 1);
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [RW-1:0] r_ring_cnt, w_ring_nxt;
  logic [W-1:0]  r_snooze_left, w_snooze_nxt;
  logic          r_stop_prev, r_snooze_prev;
  logic          w_stop_edge, w_snooze_edge, w_snz_tick, w_stay_ringing;
  logic [TW-1:0] r_tone_cnt, w_tone_cnt_nxt;
  logic          r_tone, w_tone_nxt, w_beat_on_nxt, w_led_nxt;
  logic          r_buzzer, r_led, r_ringing, r_snoozed;

  // History registers reset to 1 so a button held through reset release yields no edge
  assign w_stop_edge    = stop_btn & ~r_stop_prev;
  assign w_snooze_edge  = snooze_btn & ~r_snooze_prev;
  assign w_stay_ringing = (r_state == ST_RINGING) && (w_state_nxt == ST_RINGING);

  // BEAT_CYCLES is consumed only by the cadence build; the guard keeps it referenced in both
  if (BEAT_CYCLES < 1) begin : g_beat_cycles_unset
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ring_nxt   = r_ring_cnt;
    w_snooze_nxt = r_snooze_left;
    w_snz_tick   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ring_nxt   = '0;
        w_snooze_nxt = '0;
        if (alarm_hit && alarm_en) begin
          w_state_nxt = ST_RINGING;
          w_ring_nxt  = RW'(RING_SEC);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RINGING: begin
        if (!alarm_en || w_stop_edge) begin
          w_state_nxt = ST_IDLE;
          w_ring_nxt  = '0;
        end else if (w_snooze_edge) begin
          w_state_nxt  = ST_SNOOZED;
          w_ring_nxt   = '0;
          w_snooze_nxt = W'(SNOOZE_SEC);
        end else if (sec_tick) begin
          if (r_ring_cnt == RW'(1)) begin
            w_state_nxt = ST_IDLE;
            w_ring_nxt  = '0;
          end else begin
            w_ring_nxt = r_ring_cnt - RW'(1);
          end
        end else begin
          w_state_nxt = ST_RINGING;
        end
      end
      ST_SNOOZED: begin
        if (!alarm_en || w_stop_edge) begin
          w_state_nxt  = ST_IDLE;
          w_snooze_nxt = '0;
        end else if (sec_tick) begin
          if (r_snooze_left == W'(1)) begin
            w_state_nxt  = ST_RINGING;
            w_ring_nxt   = RW'(RING_SEC);
            w_snooze_nxt = '0;
          end else begin
            w_snooze_nxt = r_snooze_left - W'(1);
            w_snz_tick   = 1'b1;
          end
        end else begin
          w_state_nxt = ST_SNOOZED;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_ring_nxt   = '0;
        w_snooze_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ring_cnt    <= '0;
      r_snooze_left <= '0;
      r_stop_prev   <= 1'b1;
      r_snooze_prev <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_ring_cnt    <= w_ring_nxt;
      r_snooze_left <= w_snooze_nxt;
      r_stop_prev   <= stop_btn;
      r_snooze_prev <= snooze_btn;
    end
  end

`ifdef ALARM_CADENCE_EN
  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  logic [BW-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic          r_beat_on;

  // Beat phase starts "on" at ring entry and flips every BEAT_CYCLES clocks
  always_comb begin
    w_beat_cnt_nxt = '0;
    w_beat_on_nxt  = (w_state_nxt == ST_RINGING);
    if (w_stay_ringing) begin
      if (r_beat_cnt == BW'(BEAT_CYCLES - 1)) begin
        w_beat_on_nxt = ~r_beat_on;
      end else begin
        w_beat_cnt_nxt = r_beat_cnt + BW'(1);
        w_beat_on_nxt  = r_beat_on;
      end
    end else begin
      w_beat_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_beat_on  <= 1'b0;
    end else begin
      r_beat_cnt <= w_beat_cnt_nxt;
      r_beat_on  <= w_beat_on_nxt;
    end
  end
`else
  assign w_beat_on_nxt = 1'b1;
`endif

  always_comb begin
    w_tone_cnt_nxt = '0;
    w_tone_nxt     = 1'b0;
    if (w_stay_ringing) begin
      if (r_tone_cnt == TW'(TONE_DIV - 1)) begin
        w_tone_nxt = ~r_tone;
      end else begin
        w_tone_cnt_nxt = r_tone_cnt + TW'(1);
        w_tone_nxt     = r_tone;
      end
    end else begin
      w_tone_nxt = 1'b0;
    end
    case (w_state_nxt)
      ST_RINGING: w_led_nxt = w_beat_on_nxt;
      ST_SNOOZED: w_led_nxt = (r_state != ST_SNOOZED) ? 1'b1 : (w_snz_tick ? ~r_led : r_led);
      default:    w_led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
      r_buzzer   <= 1'b0;
      r_led      <= 1'b0;
      r_ringing  <= 1'b0;
      r_snoozed  <= 1'b0;
    end else begin
      r_tone_cnt <= w_tone_cnt_nxt;
      r_tone     <= w_tone_nxt;
      r_buzzer   <= w_tone_nxt & w_beat_on_nxt;
      r_led      <= w_led_nxt;
      r_ringing  <= (w_state_nxt == ST_RINGING);
      r_snoozed  <= (w_state_nxt == ST_SNOOZED);
    end
  end

  assign buzzer      = r_buzzer;
  assign led_alarm   = r_led;
  assign ringing     = r_ringing;
  assign snoozed     = r_snoozed;
  assign snooze_left = r_snooze_left;

endmodule
